// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit - iterative restoring divider for the RV32M execute stage.
// Executes DIV, DIVU, REM and REMU. One trial subtraction per cycle, MSB first.
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   start    request, accepted only while ready=1
//   op       funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend rs1 value, sampled on acceptance
//   divisor  rs2 value, sampled on acceptance
//   flush    synchronous abort back to IDLE (beats ack and start)
//   ready    unit idle, start may be issued
//   result   quotient or remainder selected by op[1]
//   valid    result valid, held until ack
//   ack      consumer takes result (ignored while valid=0)
// ---------------------------------------------------------------------------
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            flush,
   output logic            ready,
   output logic [XLEN-1:0] result,
   output logic            valid,
   input  logic            ack
);

   localparam int unsigned CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t          state;
   logic            sel_rem;
   logic            q_neg;
   logic            r_neg;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] quo;   // holds the dividend bits, shifted out as quotient bits shift in
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;

   logic            is_signed;
   logic            a_neg;
   logic            b_neg;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic            div_zero;
   logic            ovf;
   logic [XLEN:0]   rem_sh;
   logic            fits;
   logic [XLEN-1:0] diff;

   // Operand classification and magnitude conversion at acceptance
   always_comb begin
      is_signed = ~op[0];
      a_neg     = is_signed & dividend[XLEN-1];
      b_neg     = is_signed & divisor[XLEN-1];
      a_mag     = a_neg ? (~dividend + XLEN'(1)) : dividend;
      b_mag     = b_neg ? (~divisor + XLEN'(1)) : divisor;
      div_zero  = (divisor == '0);
      ovf       = is_signed & (dividend == {1'b1, {(XLEN-1){1'b0}}}) & (&divisor);
   end

   // One restoring step: shift in next dividend bit, trial-subtract divisor.
   // The remainder is always below the divisor, so the kept difference fits XLEN bits.
   always_comb begin
      rem_sh = {rem, quo[XLEN-1]};
      fits   = (rem_sh >= {1'b0, dvs});
      diff   = XLEN'(rem_sh - {1'b0, dvs});
   end

   // Control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         ready   <= 1'b1;
         valid   <= 1'b0;
         result  <= '0;
         sel_rem <= 1'b0;
         q_neg   <= 1'b0;
         r_neg   <= 1'b0;
         cnt     <= '0;
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
      end else if (flush) begin
         state <= IDLE;
         ready <= 1'b1;
         valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  ready   <= 1'b0;
                  sel_rem <= op[1];
                  q_neg   <= 1'b0;
                  r_neg   <= 1'b0;
                  cnt     <= '0;
                  if (div_zero) begin
                     quo   <= '1;
                     rem   <= dividend;
                     state <= DONE;
                  end else if (ovf) begin
                     quo   <= dividend;
                     rem   <= '0;
                     state <= DONE;
                  end else begin
                     quo   <= a_mag;
                     rem   <= '0;
                     dvs   <= b_mag;
                     q_neg <= a_neg ^ b_neg;
                     r_neg <= a_neg;
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= fits ? diff : rem_sh[XLEN-1:0];
               quo <= {quo[XLEN-2:0], fits};
               if (cnt == CW'(XLEN - 1)) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            FIX: begin
               if (q_neg) begin
                  quo <= ~quo + XLEN'(1);
               end
               if (r_neg && (rem != '0)) begin
                  rem <= ~rem + XLEN'(1);
               end
               state <= DONE;
            end
            DONE: begin
               // First DONE cycle registers the result; afterwards hold until ack
               if (valid) begin
                  if (ack) begin
                     valid <= 1'b0;
                     ready <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  valid  <= 1'b1;
                  result <= sel_rem ? rem : quo;
               end
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit - scoreboard bench for div_unit (XLEN=32).
// Driver pushes expected result/latency per accepted op; a monitor pops and
// compares whenever valid rises.
// ---------------------------------------------------------------------------
module tb_div_unit;

   localparam int unsigned XLEN = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            flush;
   logic            ready;
   logic [XLEN-1:0] result;
   logic            valid;
   logic            ack;

   div_unit #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .dividend(dividend), .divisor(divisor), .flush(flush),
      .ready(ready), .result(result), .valid(valid), .ack(ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Reference: RISC-V M semantics in plain arithmetic
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; r = a;
      end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = a; r = 32'd0;
      end else if (!o[0]) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return o[1] ? r : q;
   endfunction

   function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return XLEN + 2;
   endfunction

   // Monitor: one comparison per rising valid
   logic seen = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (valid && !seen) begin
         seen = 1'b1;
         if (sb.size() == 0) begin
            fail_now("unexpected_result");
         end else begin
            e = sb.pop_front();
            chk("result", result, e.res);
            chk("latency", 32'(cyc - e.acc), 32'(e.lat));
         end
      end else if (!valid) begin
         seen = 1'b0;
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (!ready && t < 100) begin @(negedge clk); t++; end
      if (!ready) fail_now("ready_timeout");
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] res);
      int t = 0;
      logic [31:0] e;
      wait_ready();
      e = model(o, a, b);
      start = 1'b1; op = o; dividend = a; divisor = b;
      sb.push_back('{e, model_lat(o, a, b), cyc + 1});
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom; divisor = $urandom; op = 2'($urandom);
      chk("ready_busy", 32'(ready), 32'd0);
      while (!valid && t < 100) begin @(negedge clk); t++; end
      if (!valid) begin
         fail_now("valid_timeout");
         res = 'x;
         return;
      end
      res = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", 32'(valid), 32'd1);
         chk("hold_result", result, e);
         chk("hold_ready", 32'(ready), 32'd0);
      end
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ready_after_ack", 32'(ready), 32'd1);
      chk("valid_after_ack", 32'(valid), 32'd0);
   endtask

   initial begin
      logic [31:0] r, q, rr, a, b;
      logic [1:0]  qop;
      int          t;
      rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0; flush = 1'b0; ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_ready", 32'(ready), 32'd1);
      chk("reset_valid", 32'(valid), 32'd0);
      chk("reset_result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases
      run_op(2'b01, 32'd100, 32'd7, 0, r);            chk("divu_100_7", r, 32'd14);
      run_op(2'b11, 32'd100, 32'd7, 0, r);            chk("remu_100_7", r, 32'd2);
      run_op(2'b00, -32'sd7, 32'd2, 0, r);            chk("div_m7_2", r, 32'hFFFF_FFFD);
      run_op(2'b10, -32'sd7, 32'd2, 0, r);            chk("rem_m7_2", r, 32'hFFFF_FFFF);
      run_op(2'b10, 32'd7, -32'sd2, 0, r);            chk("rem_7_m2", r, 32'd1);
      run_op(2'b01, 32'h1234, 32'd0, 0, r);           chk("divu_by0", r, 32'hFFFF_FFFF);
      run_op(2'b10, 32'h1234, 32'd0, 0, r);           chk("rem_by0", r, 32'h1234);
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, r); chk("div_ovf", r, 32'h8000_0000);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, r); chk("rem_ovf", r, 32'd0);

      // Held ack then back-to-back start right after the ack edge
      run_op(2'b01, 32'd1000, 32'd3, 5, r);           chk("divu_hold", r, 32'd333);
      run_op(2'b11, 32'hFFFF_FFFF, 32'd16, 0, r);     chk("remu_b2b", r, 32'd15);

      // ack held high through a special case: ignored while valid=0
      wait_ready();
      start = 1'b1; ack = 1'b1; op = 2'b01; dividend = 32'h55; divisor = 32'd0;
      sb.push_back('{32'hFFFF_FFFF, 1, cyc + 1});
      @(negedge clk); start = 1'b0;
      chk("ackearly_valid0", 32'(valid), 32'd0);
      @(negedge clk);
      chk("ackearly_valid1", 32'(valid), 32'd1);
      @(negedge clk);
      chk("ackearly_released", 32'(valid), 32'd0);
      chk("ackearly_ready", 32'(ready), 32'd1);
      ack = 1'b0;

      // flush and start together in IDLE: not accepted
      start = 1'b1; flush = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      @(negedge clk); start = 1'b0; flush = 1'b0;
      chk("flushstart_ready", 32'(ready), 32'd1);
      repeat (3) @(negedge clk);
      chk("flushstart_valid", 32'(valid), 32'd0);

      // Flush at iteration 10
      wait_ready();
      start = 1'b1; op = 2'b01; dividend = 32'd12345; divisor = 32'd7;
      @(negedge clk); start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      chk("flush_valid", 32'(valid), 32'd0);
      chk("flush_ready", 32'(ready), 32'd1);
      repeat (40) @(negedge clk);
      chk("flush_no_stale", 32'(valid), 32'd0);

      // Asynchronous reset at iteration 20
      start = 1'b1; op = 2'b00; dividend = -32'sd999; divisor = 32'd13;
      @(negedge clk); start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_mid_valid", 32'(valid), 32'd0);
      chk("rst_mid_ready", 32'(ready), 32'd1);
      chk("rst_mid_result", result, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("rst_no_stale", 32'(valid), 32'd0);

      // Random sweep: quotient then remainder for the same operands
      for (int i = 0; i < 40; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : 32'($urandom);
         if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(0, 31);
         if (i == 7) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         qop = {1'b0, 1'($urandom)};
         run_op(qop, a, b, $urandom_range(0, 2), q);
         run_op({1'b1, qop[0]}, a, b, 0, rr);
         chk("identity", q * b + rr, a);
         if (!qop[0] && rr != 32'd0) chk("rem_sign", 32'(rr[31]), 32'(a[31]));
      end

      t = 0;
      while (sb.size() != 0 && t < 100) begin @(negedge clk); t++; end
      if (sb.size() != 0) fail_now("scoreboard_not_drained");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
